// File: rtl/qam_symbol_mapper.sv
// qam_symbol_mapper
//   Collects serial bits into symbols and maps each symbol to signed I/Q
//   amplitudes for the shaping filter. QPSK (2 bits/symbol) and 16QAM
//   (4 bits/symbol). bit_clk and sym_clk are treated as data on clk_in and
//   edge-detected.
//
//   Optional feature macro: MAP_PRBS_EN
//     defined   -> bit_in ignored; bits come from an internal PRBS-9 LFSR
//                  (x^9 + x^5 + 1), seeded to 9'h1FF on rst, advanced per bit.
//     undefined -> bit_in is the data source; no LFSR logic.
//
// Ports:
//   clk_in     in   system clock (only clock)
//   rst        in   synchronous active-high reset
//   mod_type   in   0 = QPSK, 1 = 16QAM
//   bit_clk    in   bit-rate square wave; rising edge = new bit
//   sym_clk    in   symbol-rate square wave; rising edge = symbol boundary
//   bit_in     in   serial data, valid at bit_clk rising edge
//   i_out      out  signed in-phase amplitude, held between symbols
//   q_out      out  signed quadrature amplitude, held between symbols
//   sym_idx    out  raw symbol bits, first-received bit is MSB
//   sym_valid  out  one-cycle pulse when a new symbol is presented
//   sync_err   out  one-cycle pulse on a boundary with the wrong bit count
module qam_symbol_mapper #(
    parameter int IQ_W   = 8,
    parameter int LVL_Q  = 64,
    parameter int LVL_HI = 96,
    parameter int LVL_LO = 32
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   mod_type,
    input  logic                   bit_clk,
    input  logic                   sym_clk,
    input  logic                   bit_in,
    output logic signed [IQ_W-1:0] i_out,
    output logic signed [IQ_W-1:0] q_out,
    output logic [3:0]             sym_idx,
    output logic                   sym_valid,
    output logic                   sync_err
);

    localparam logic signed [IQ_W-1:0] POS_Q  = IQ_W'(LVL_Q);
    localparam logic signed [IQ_W-1:0] NEG_Q  = -POS_Q;
    localparam logic signed [IQ_W-1:0] POS_HI = IQ_W'(LVL_HI);
    localparam logic signed [IQ_W-1:0] NEG_HI = -POS_HI;
    localparam logic signed [IQ_W-1:0] POS_LO = IQ_W'(LVL_LO);
    localparam logic signed [IQ_W-1:0] NEG_LO = -POS_LO;

    // Gray pair per axis: 00 -> +HI, 01 -> +LO, 11 -> -LO, 10 -> -HI
    function automatic logic signed [IQ_W-1:0] gray_level(input logic [1:0] p);
        case (p)
            2'b00:   gray_level = POS_HI;
            2'b01:   gray_level = POS_LO;
            2'b11:   gray_level = NEG_LO;
            default: gray_level = NEG_HI;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Input sampling and edge detection
    // ------------------------------------------------------------------
    logic bit_clk_r0, bit_clk_r1;
    logic sym_clk_r0, sym_clk_r1;
    logic mod_type_r;
    logic bit_edge, sym_edge;
    logic ser_bit;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            bit_clk_r0 <= 1'b0;
            bit_clk_r1 <= 1'b0;
            sym_clk_r0 <= 1'b0;
            sym_clk_r1 <= 1'b0;
            mod_type_r <= 1'b0;
        end else begin
            bit_clk_r0 <= bit_clk;
            bit_clk_r1 <= bit_clk_r0;
            sym_clk_r0 <= sym_clk;
            sym_clk_r1 <= sym_clk_r0;
            mod_type_r <= mod_type;
        end
    end

    assign bit_edge = bit_clk_r0 & ~bit_clk_r1;
    assign sym_edge = sym_clk_r0 & ~sym_clk_r1;

`ifdef MAP_PRBS_EN
    // Serial bit is the LFSR MSB before the shift; taps at bits 9 and 5.
    logic [8:0] lfsr;

    always_ff @(posedge clk_in) begin
        if (rst)
            lfsr <= 9'h1FF;
        else if (bit_edge)
            lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end

    assign ser_bit = lfsr[8];
`else
    logic bit_in_r0;

    always_ff @(posedge clk_in) begin
        if (rst)
            bit_in_r0 <= 1'b0;
        else
            bit_in_r0 <= bit_in;
    end

    assign ser_bit = bit_in_r0;
`endif

    // ------------------------------------------------------------------
    // Bit collection and symbol decision
    // ------------------------------------------------------------------
    logic [3:0] shift_q, shift_next, shift_d;
    logic [2:0] bit_cnt, cnt_next, cnt_d;
    logic [2:0] bps;
    logic       resync, resync_d;
    logic       mod_chg;
    logic       hit, err;

    assign bps     = mod_type_r ? 3'd4 : 3'd2;
    // mod_type_r is about to take a new value this cycle
    assign mod_chg = mod_type ^ mod_type_r;

    // A bit arriving with the boundary is shifted in before the decision
    assign cnt_next   = bit_edge ? ((bit_cnt == 3'd7) ? 3'd7 : bit_cnt + 3'd1) : bit_cnt;
    assign shift_next = bit_edge ? {shift_q[2:0], ser_bit} : shift_q;

    always_comb begin
        cnt_d    = cnt_next;
        shift_d  = shift_next;
        resync_d = resync;
        hit      = 1'b0;
        err      = 1'b0;
        if (mod_chg) begin
            // Mode change wins over a coincident boundary: that boundary is
            // swallowed and the next one is the silent resync.
            cnt_d    = 3'd0;
            shift_d  = 4'd0;
            resync_d = 1'b1;
        end else if (sym_edge) begin
            cnt_d = 3'd0;
            if (resync)
                resync_d = 1'b0;
            else if (cnt_next == bps)
                hit = 1'b1;
            else
                err = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            shift_q <= 4'd0;
            bit_cnt <= 3'd0;
            resync  <= 1'b1;
        end else begin
            shift_q <= shift_d;
            bit_cnt <= cnt_d;
            resync  <= resync_d;
        end
    end

    // ------------------------------------------------------------------
    // Mapping
    // ------------------------------------------------------------------
    logic [3:0]             map_idx;
    logic signed [IQ_W-1:0] map_i, map_q;

    always_comb begin
        if (mod_type_r) begin
            map_idx = shift_next;
            map_i   = gray_level(shift_next[3:2]);
            map_q   = gray_level(shift_next[1:0]);
        end else begin
            map_idx = {2'b00, shift_next[1:0]};
            map_i   = shift_next[1] ? NEG_Q : POS_Q;
            map_q   = shift_next[0] ? NEG_Q : POS_Q;
        end
    end

    // ------------------------------------------------------------------
    // Two-stage output pipeline: decision stage, then presentation stage.
    // sym_valid lands two clk_in cycles after sym_clk is first sampled high.
    // ------------------------------------------------------------------
    logic                   s1_vld, s1_err;
    logic [3:0]             s1_idx;
    logic signed [IQ_W-1:0] s1_i, s1_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_err    <= 1'b0;
            s1_idx    <= 4'd0;
            s1_i      <= '0;
            s1_q      <= '0;
            sym_valid <= 1'b0;
            sync_err  <= 1'b0;
            sym_idx   <= 4'd0;
            i_out     <= '0;
            q_out     <= '0;
        end else begin
            s1_vld    <= hit;
            s1_err    <= err;
            if (hit) begin
                s1_idx <= map_idx;
                s1_i   <= map_i;
                s1_q   <= map_q;
            end
            sym_valid <= s1_vld;
            sync_err  <= s1_err;
            if (s1_vld) begin
                sym_idx <= s1_idx;
                i_out   <= s1_i;
                q_out   <= s1_q;
            end
        end
    end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
module tb_qam_symbol_mapper;

    logic              clk_in = 1'b0;
    logic              rst = 1'b1;
    logic              mod_type = 1'b0;
    logic              bit_clk = 1'b0;
    logic              sym_clk = 1'b0;
    logic              bit_in = 1'b0;
    logic signed [7:0] i_out, q_out;
    logic [3:0]        sym_idx;
    logic              sym_valid, sync_err;

    int checks = 0;
    int errors = 0;
    int nv = 0;   // sym_valid cycles seen
    int ne = 0;   // sync_err cycles seen

    qam_symbol_mapper #(.IQ_W(8), .LVL_Q(64), .LVL_HI(96), .LVL_LO(32)) dut (
        .clk_in(clk_in), .rst(rst), .mod_type(mod_type), .bit_clk(bit_clk),
        .sym_clk(sym_clk), .bit_in(bit_in), .i_out(i_out), .q_out(q_out),
        .sym_idx(sym_idx), .sym_valid(sym_valid), .sync_err(sync_err)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (sym_valid === 1'b1) nv++;
        if (sync_err === 1'b1) ne++;
    end

    // All tasks enter and leave on a negedge.
    task automatic send_bit(input logic b);
        bit_in  = b;
        bit_clk = 1'b1;
        repeat (4) @(negedge clk_in);
        bit_clk = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic sym_pulse();
        sym_clk = 1'b1;
        repeat (4) @(negedge clk_in);
        sym_clk = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic send_bits(input logic [11:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) send_bit(v[k]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk_in);
        checks++;
        if (i_out !== 8'sd0 || q_out !== 8'sd0 || sym_idx !== 4'd0 ||
            sym_valid !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: i=%0d q=%0d idx=%b v=%b e=%b, want all 0",
                     i_out, q_out, sym_idx, sym_valid, sync_err);
        end
        rst = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_first_resync();
        int v0, e0;
        v0 = nv; e0 = ne;
        send_bit(1'b1);
        sym_pulse();
        checks++;
        if (nv != v0 || ne != e0) begin
            errors++;
            $display("FAIL first_resync: valid=%0d err=%0d, want 0 0", nv - v0, ne - e0);
        end
    endtask

    task automatic test_qpsk();
        int v0;
        v0 = nv;
        send_bits(12'b10, 2);
        sym_pulse();
        checks++;
        if (nv - v0 != 1) begin
            errors++;
            $display("FAIL qpsk_valid_count: got %0d, want 1", nv - v0);
        end
        checks++;
        if (sym_idx !== 4'b0010 || i_out !== -8'sd64 || q_out !== 8'sd64) begin
            errors++;
            $display("FAIL qpsk_map: idx=%b i=%0d q=%0d, want 0010 -64 64", sym_idx, i_out, q_out);
        end
    endtask

    task automatic test_sync_err();
        int v0, e0;
        v0 = nv; e0 = ne;
        send_bits(12'b110, 3);
        sym_pulse();
        checks++;
        if (ne - e0 != 1 || nv != v0) begin
            errors++;
            $display("FAIL sync_err_3bits: err=%0d valid=%0d, want 1 0", ne - e0, nv - v0);
        end
        checks++;
        if (i_out !== -8'sd64 || q_out !== 8'sd64) begin
            errors++;
            $display("FAIL sync_err_hold: i=%0d q=%0d, want -64 64", i_out, q_out);
        end
    endtask

    task automatic test_mode_switch();
        int v0, e0;
        v0 = nv; e0 = ne;
        send_bit(1'b1);
        mod_type = 1'b1;          // mid-symbol switch to 16QAM
        @(negedge clk_in);
        send_bit(1'b1);
        sym_pulse();
        checks++;
        if (nv != v0 || ne != e0) begin
            errors++;
            $display("FAIL mode_switch_silent: valid=%0d err=%0d, want 0 0", nv - v0, ne - e0);
        end
        // 0,1,1,0 with latency check
        send_bits(12'b0110, 4);
        sym_clk = 1'b1;
        @(negedge clk_in);        // first posedge sampling sym_clk high has passed
        @(negedge clk_in);
        checks++;
        if (sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: sym_valid=%b one cycle after sample, want 0", sym_valid);
        end
        @(negedge clk_in);
        checks++;
        if (sym_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: sym_valid=%b two cycles after sample, want 1", sym_valid);
        end
        checks++;
        if (sym_idx !== 4'b0110 || i_out !== 8'sd32 || q_out !== -8'sd96) begin
            errors++;
            $display("FAIL qam16_0110: idx=%b i=%0d q=%0d, want 0110 32 -96", sym_idx, i_out, q_out);
        end
        @(negedge clk_in);
        sym_clk = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic test_stream();
        logic signed [7:0] hi, hq;
        send_bits(12'b1010, 4);
        sym_pulse();
        checks++;
        if (sym_idx !== 4'b1010 || i_out !== -8'sd96 || q_out !== -8'sd96) begin
            errors++;
            $display("FAIL stream_sym1: idx=%b i=%0d q=%0d, want 1010 -96 -96", sym_idx, i_out, q_out);
        end
        hi = i_out; hq = q_out;
        send_bits(12'b001, 3);
        checks++;
        if (i_out !== -8'sd96 || q_out !== -8'sd96 || hi !== -8'sd96 || hq !== -8'sd96) begin
            errors++;
            $display("FAIL stream_hold: i=%0d q=%0d, want -96 -96", i_out, q_out);
        end
        send_bit(1'b1);
        sym_pulse();
        checks++;
        if (sym_idx !== 4'b0011 || i_out !== 8'sd96 || q_out !== -8'sd32) begin
            errors++;
            $display("FAIL stream_sym2: idx=%b i=%0d q=%0d, want 0011 96 -32", sym_idx, i_out, q_out);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = nv;
        send_bits(12'b110, 3);
        // last bit and boundary rise in the same cycle
        bit_in  = 1'b1;
        bit_clk = 1'b1;
        sym_clk = 1'b1;
        repeat (4) @(negedge clk_in);
        bit_clk = 1'b0;
        sym_clk = 1'b0;
        repeat (4) @(negedge clk_in);
        checks++;
        if (nv - v0 != 1 || sym_idx !== 4'b1101 || i_out !== -8'sd32 || q_out !== 8'sd32) begin
            errors++;
            $display("FAIL simultaneous_edges: valid=%0d idx=%b i=%0d q=%0d, want 1 1101 -32 32",
                     nv - v0, sym_idx, i_out, q_out);
        end
    endtask

    task automatic test_saturation();
        int v0, e0;
        v0 = nv; e0 = ne;
        sym_pulse();              // boundary with zero bits
        checks++;
        if (ne - e0 != 1 || nv != v0) begin
            errors++;
            $display("FAIL zero_bits: err=%0d valid=%0d, want 1 0", ne - e0, nv - v0);
        end
        e0 = ne;
        send_bits(12'b0000_0000_0000, 12);   // 12 bits would wrap to 4 without saturation
        sym_pulse();
        checks++;
        if (ne - e0 != 1 || nv != v0) begin
            errors++;
            $display("FAIL saturate_12bits: err=%0d valid=%0d, want 1 0", ne - e0, nv - v0);
        end
        checks++;
        if (i_out !== -8'sd32 || q_out !== 8'sd32) begin
            errors++;
            $display("FAIL saturate_hold: i=%0d q=%0d, want -32 32", i_out, q_out);
        end
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        send_bits(12'b11, 2);
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++;
        if (i_out !== 8'sd0 || q_out !== 8'sd0 || sym_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: i=%0d q=%0d idx=%b, want 0 0 0000", i_out, q_out, sym_idx);
        end
        rst = 1'b0;
        @(negedge clk_in);
        v0 = nv; e0 = ne;
        send_bit(1'b1);
        sym_pulse();
        checks++;
        if (nv != v0 || ne != e0) begin
            errors++;
            $display("FAIL reset_mid_resync: valid=%0d err=%0d, want 0 0", nv - v0, ne - e0);
        end
        send_bits(12'b1001, 4);
        sym_pulse();
        checks++;
        if (nv - v0 != 1 || sym_idx !== 4'b1001 || i_out !== -8'sd96 || q_out !== 8'sd32) begin
            errors++;
            $display("FAIL reset_mid_decode: valid=%0d idx=%b i=%0d q=%0d, want 1 1001 -96 32",
                     nv - v0, sym_idx, i_out, q_out);
        end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_first_resync();
        test_qpsk();
        test_sync_err();
        test_mode_switch();
        test_stream();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
